// File: rtl/cmp.sv
// Registered 32-bit subtract/compare unit: one result per clock, with the
// difference, carry/overflow, NZCV flags and signed/unsigned relations.
module cmp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] In1,
    input  logic [31:0] In2,
    output logic [31:0] Out,
    output logic        Carry,
    output logic        Overflow,
    output logic [3:0]  flag,
    output logic        lt_s,
    output logic        eq,
    output logic        gt_s,
    output logic        lt_u,
    output logic        gt_u
);

    logic [32:0] sum_next;
    logic [31:0] diff_next;
    logic        c_next;
    logic        v_next;
    logic        n_next;
    logic        z_next;
    logic        lt_s_next;
    logic        gt_s_next;
    logic        lt_u_next;
    logic        gt_u_next;

    // Subtraction as In1 + ~In2 + 1 so the carry-out means "no unsigned borrow".
    always_comb begin
        sum_next  = {1'b0, In1} + {1'b0, ~In2} + 33'd1;
        diff_next = sum_next[31:0];
        c_next    = sum_next[32];
        v_next    = (In1[31] != In2[31]) && (diff_next[31] != In1[31]);
        n_next    = diff_next[31];
        z_next    = (diff_next == 32'd0);
        lt_s_next = n_next ^ v_next;
        gt_s_next = ~lt_s_next & ~z_next;
        lt_u_next = ~c_next;
        gt_u_next = c_next & ~z_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Out      <= 32'd0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
            flag     <= 4'b0000;
            lt_s     <= 1'b0;
            eq       <= 1'b0;
            gt_s     <= 1'b0;
            lt_u     <= 1'b0;
            gt_u     <= 1'b0;
        end else begin
            Out      <= diff_next;
            Carry    <= c_next;
            Overflow <= v_next;
            flag     <= {n_next, z_next, c_next, v_next};
            lt_s     <= lt_s_next;
            eq       <= z_next;
            gt_s     <= gt_s_next;
            lt_u     <= lt_u_next;
            gt_u     <= gt_u_next;
        end
    end

endmodule

// File: tb/tb_cmp.sv
// Self-checking bench for cmp: directed vectors, randomized operands against an
// arithmetic reference model, a gap-free stream and asynchronous reset behaviour.
module tb_cmp;

    logic        clk;
    logic        rst_n;
    logic [31:0] In1;
    logic [31:0] In2;
    logic [31:0] Out;
    logic        Carry;
    logic        Overflow;
    logic [3:0]  flag;
    logic        lt_s;
    logic        eq;
    logic        gt_s;
    logic        lt_u;
    logic        gt_u;

    int total;
    int bad;

    logic [42:0] obs;
    assign obs = {Out, Carry, Overflow, flag, lt_s, eq, gt_s, lt_u, gt_u};

    cmp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .In1      (In1),
        .In2      (In2),
        .Out      (Out),
        .Carry    (Carry),
        .Overflow (Overflow),
        .flag     (flag),
        .lt_s     (lt_s),
        .eq       (eq),
        .gt_s     (gt_s),
        .lt_u     (lt_u),
        .gt_u     (gt_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: relations from direct signed/unsigned comparison, overflow from
    // whether the exact 64-bit difference fits in the wrapped 32-bit result.
    function automatic logic [42:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        longint      sa;
        longint      sb;
        longint      exact;
        logic        c;
        logic        v;
        d     = a - b;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        exact = sa - sb;
        v     = (exact != longint'($signed(d)));
        c     = (a >= b);
        return {d, c, v, {d[31], (a == b), c, v},
                (sa < sb), (a == b), (sa > sb), (a < b), (a > b)};
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] edges [5];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'h0000_0001;
        edges[2] = 32'h7FFF_FFFF;
        edges[3] = 32'h8000_0000;
        edges[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0)
            return edges[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        In1   = 32'h1234_5678;
        In2   = 32'h0000_0001;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs !== 43'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h exp=%h", obs, 43'd0);
        end
        // First edge after release must load the operands already present.
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (obs !== model(In1, In2)) begin
            bad++;
            $display("FAIL reset_release got=%h exp=%h", obs, model(In1, In2));
        end
        $display("txn reset_release a=%h b=%h out=%h flag=%b", In1, In2, Out, flag);
    endtask

    task automatic test_directed();
        logic [31:0] ta [8];
        logic [31:0] tb [8];
        logic [31:0] tout [8];
        logic [3:0]  tflag [8];
        ta[0] = 32'd10;         tb[0] = -32'sd15;      tout[0] = 32'd25;         tflag[0] = 4'b0000;
        ta[1] = 32'd7;          tb[1] = -32'sd2;       tout[1] = 32'd9;          tflag[1] = 4'b0000;
        ta[2] = 32'd5;          tb[2] = 32'd5;         tout[2] = 32'd0;          tflag[2] = 4'b0110;
        ta[3] = 32'd0;          tb[3] = -32'sd1;       tout[3] = 32'd1;          tflag[3] = 4'b0000;
        ta[4] = -32'sd32768;    tb[4] = 32'd32767;     tout[4] = 32'hFFFF_0001;  tflag[4] = 4'b1010;
        ta[5] = 32'h7FFF_FFFF;  tb[5] = -32'sd1;       tout[5] = 32'h8000_0000;  tflag[5] = 4'b1001;
        ta[6] = 32'h8000_0000;  tb[6] = 32'h8000_0000; tout[6] = 32'd0;          tflag[6] = 4'b0110;
        ta[7] = 32'h8000_0000;  tb[7] = 32'd1;         tout[7] = 32'h7FFF_FFFF;  tflag[7] = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            In1 = ta[i];
            In2 = tb[i];
            @(posedge clk);
            #1;
            $display("txn directed%0d a=%h b=%h out=%h flag=%b", i, ta[i], tb[i], Out, flag);
            total++;
            if (Out !== tout[i] || flag !== tflag[i]) begin
                bad++;
                $display("FAIL directed%0d_out_flag got=%h/%b exp=%h/%b", i, Out, flag, tout[i], tflag[i]);
            end
            total++;
            if (obs !== model(ta[i], tb[i])) begin
                bad++;
                $display("FAIL directed%0d_all got=%h exp=%h", i, obs, model(ta[i], tb[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [42:0] exp;
        for (int i = 0; i < 150; i++) begin
            In1 = pick_operand();
            In2 = ($urandom_range(0, 9) == 0) ? In1 : pick_operand();
            exp = model(In1, In2);
            @(posedge clk);
            #1;
            $display("txn random%0d a=%h b=%h out=%h flag=%b", i, In1, In2, Out, flag);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL random%0d got=%h exp=%h", i, obs, exp);
            end
            total++;
            if ($countones({lt_s, eq, gt_s}) != 1 || $countones({lt_u, eq, gt_u}) != 1) begin
                bad++;
                $display("FAIL random%0d_onehot got=%b%b%b/%b%b%b exp=one-hot", i,
                         lt_s, eq, gt_s, lt_u, eq, gt_u);
            end
        end
    endtask

    // New operands every cycle; each result is checked against the operands of
    // the immediately preceding edge.
    task automatic test_back_to_back();
        logic [42:0] exp;
        for (int i = 0; i < 40; i++) begin
            In1 = $urandom;
            In2 = $urandom;
            exp = model(In1, In2);
            @(posedge clk);
            #1;
            $display("txn stream%0d a=%h b=%h out=%h flag=%b", i, In1, In2, Out, flag);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL stream%0d got=%h exp=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_midstream_reset();
        In1 = 32'h7FFF_FFFF;
        In2 = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        total++;
        if (Out !== 32'h8000_0000 || flag !== 4'b1001 || gt_s !== 1'b1 || Overflow !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset got=%h/%b exp=80000000/1001", Out, flag);
        end
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn midreset out=%h flag=%b", Out, flag);
        total++;
        if (obs !== 43'd0) begin
            bad++;
            $display("FAIL async_reset got=%h exp=%h", obs, 43'd0);
        end
        @(posedge clk);
        #1;
        total++;
        if (obs !== 43'd0) begin
            bad++;
            $display("FAIL reset_clocked got=%h exp=%h", obs, 43'd0);
        end
        In1   = 32'd5;
        In2   = 32'd5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("txn post_reset a=%h b=%h out=%h flag=%b", In1, In2, Out, flag);
        total++;
        if (obs !== model(32'd5, 32'd5)) begin
            bad++;
            $display("FAIL post_reset got=%h exp=%h", obs, model(32'd5, 32'd5));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        In1   = 32'd0;
        In2   = 32'd0;
        #1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_midstream_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp.md
CMP -- requirements
Module: cmp

Interface
REQ-001 The module SHALL have no parameters; all datapath widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 In1  input  32  signed minuend (two's complement).
REQ-005 In2  input  32  signed subtrahend (two's complement).
REQ-006 Out  output  32  signed difference In1 - In2, registered.
REQ-007 Carry  output  1  carry-out of In1 + ~In2 + 1, registered; 1 = no unsigned borrow.
REQ-008 Overflow  output  1  signed overflow of the subtraction, registered.
REQ-009 flag  output  4  packed condition codes {N, Z, C, V}, registered; bit 3 = N, bit 0 = V.
REQ-010 lt_s, eq, gt_s  output  1 each  signed relations In1 < In2, In1 == In2, In1 > In2, registered.
REQ-011 lt_u, gt_u  output  1 each  unsigned relations In1 < In2, In1 > In2, registered.

Function
REQ-012 The subtraction SHALL be computed as the 33-bit sum {0,In1} + {0,~In2} + 1; Out = bits[31:0]; Carry = bit 32.
REQ-013 Overflow SHALL be 1 iff In1[31] != In2[31] and Out[31] != In1[31].
REQ-014 N SHALL equal Out[31]; Z SHALL be 1 iff Out == 0; C = Carry; V = Overflow.
REQ-015 eq SHALL equal Z; lt_s SHALL equal N XOR V; gt_s SHALL equal NOT(lt_s) AND NOT(Z).
REQ-016 lt_u SHALL equal NOT(C); gt_u SHALL equal C AND NOT(Z).
REQ-017 All outputs SHALL be registered, with a latency of exactly 1 clock: inputs sampled at rising edge k are reflected on the outputs after edge k.
REQ-018 The block SHALL accept new operands on every cycle, with no handshake and no stall.
REQ-019 The arithmetic SHALL wrap modulo 2^32; no saturation is permitted.
REQ-020 Exactly one of lt_s, eq, gt_s SHALL be 1 after any post-reset clock edge; the same rule SHALL hold for lt_u, eq, gt_u.
REQ-021 In1 = In2 = 0x80000000 SHALL give Out = 0, Z = 1, C = 1, V = 0.
REQ-022 In1 = 0x80000000, In2 = 1 SHALL give Out = 0x7FFFFFFF, V = 1, lt_s = 1.
REQ-023 The block SHALL contain no combinational path from inputs to outputs.

Reset
REQ-024 While rst_n = 0, all outputs SHALL be 0 (Out = 0, Carry = 0, Overflow = 0, flag = 4'b0000, all relation bits 0), asynchronously and independent of clk.
REQ-025 On deassertion of rst_n, the first rising clk edge SHALL load results for the current inputs.
REQ-026 Reset asserted mid-stream SHALL clear the outputs immediately; no result computed before the reset is retained.

Verification
REQ-027 In1 = 10, In2 = -15 -> Out = 25, Carry = 0, Overflow = 0, flag = 0000, gt_s = 1, lt_u = 1.
REQ-028 In1 = 7, In2 = -2 -> Out = 9, Carry = 0, Overflow = 0, gt_s = 1.
REQ-029 In1 = 5, In2 = 5 -> Out = 0, Carry = 1, Overflow = 0, flag = 0110, eq = 1.
REQ-030 In1 = 0, In2 = -1 -> Out = 1, Carry = 0, Overflow = 0, gt_s = 1, lt_u = 1.
REQ-031 In1 = -32768, In2 = 32767 -> Out = -65535 (0xFFFF0001), Carry = 1, Overflow = 0, flag = 1010, lt_s = 1, gt_u = 1.
REQ-032 In1 = 0x7FFFFFFF, In2 = -1 -> Out = 0x80000000, Carry = 0, Overflow = 1, flag = 1001, gt_s = 1; then assert rst_n = 0 mid-cycle -> all outputs 0 at once.
